// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU definitions used by the fetch unit and by Control.
//   WORD_W           - instruction / address word width (16)
//   word_t           - one machine word
//   NOP_INSTR        - bubble instruction issued when nothing real is available
//   RESET_PC_DEFAULT - first fetch address after reset
//   fetch_entry_t    - one fetched instruction together with its address
//   pc_next()        - sequential byte-address increment (wraps FFFE -> 0000)
package cpu_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t NOP_INSTR        = 16'hE800;
    localparam word_t RESET_PC_DEFAULT = 16'h0000;

    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_entry_t;

    // Instructions are one word (2 bytes); natural overflow gives the wrap.
    function automatic word_t pc_next(input word_t pc);
        return pc + word_t'(2);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small instruction buffer of {pc, instr} entries.
//   clk       - rising-edge clock
//   rst       - asynchronous active-low reset, empties the buffer
//   push      - write push_data at the tail (ignored when full without a pop)
//   push_data - entry to write
//   pop       - drop the head entry (ignored when empty)
//   flush     - discard all entries; wins over push and pop
//   head      - current head entry, combinational from storage
//   count     - number of valid entries (0..DEPTH)
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     entries_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Pointer wrap works for any DEPTH, not only powers of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (do_push && !flush && (wr_ptr_q == PW'(i))) entries_q[i] <= push_data;
            end
        end
    end

    assign head  = entries_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch unit feeding Control.
//   clk, rst        - rising-edge clock, asynchronous active-low reset
//   halt            - pipeline hold: no pop, no new request
//   redirect        - taken branch/jump: flush and restart at redirect_pc
//   redirect_pc     - new fetch address, valid with redirect
//   imem_req/addr   - fetch request and its address (held until granted)
//   imem_gnt        - request accepted this cycle
//   imem_rvalid/rdata - in-order read response
//   Instruct/instr_pc/instr_valid - instruction to Control, its address, real/bubble
module instr_fetch
    import cpu_pkg::*;
#(
    parameter word_t RESET_PC = RESET_PC_DEFAULT,
    parameter word_t NOP      = NOP_INSTR,
    parameter int    DEPTH    = 2
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  halt,
    input  logic  redirect,
    input  word_t redirect_pc,
    output logic  imem_req,
    output word_t imem_addr,
    input  logic  imem_gnt,
    input  logic  imem_rvalid,
    input  word_t imem_rdata,
    output word_t Instruct,
    output word_t instr_pc,
    output logic  instr_valid
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 2;   // room for buffered + outstanding + discard

    word_t         fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;

    logic [CW-1:0] buf_count;
    fetch_entry_t  buf_head;
    fetch_entry_t  rsp_entry;
    logic          credit_ok, accept, rsp_live, rsp_drop, buf_push, buf_pop, buf_empty;

    // Every request still in flight (live or to be discarded) holds a buffer
    // slot, so a response can never find the buffer full.
    assign credit_ok = (SW'(buf_count) + SW'(outstanding_q) + SW'(discard_q)) < SW'(DEPTH);
    assign imem_req  = rst && !halt && !redirect && credit_ok;
    assign imem_addr = fetch_pc_q;
    assign accept    = imem_req && imem_gnt;

    // Stale responses are drained first; a response with nothing outstanding is ignored.
    assign rsp_drop = imem_rvalid && (discard_q != '0);
    assign rsp_live = imem_rvalid && (discard_q == '0) && (outstanding_q != '0);

    // Live requests are consecutive words ending just below fetch_pc_q, so the
    // oldest one sits 2*outstanding bytes back.
    assign rsp_entry.pc    = fetch_pc_q - (word_t'(outstanding_q) << 1);
    assign rsp_entry.instr = imem_rdata;

    assign buf_push = rsp_live && !redirect;
    assign buf_pop  = !halt && !redirect;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q - CW'(rsp_live) + CW'(accept);
        discard_d     = discard_q - CW'(rsp_drop);
        if (redirect) begin
            fetch_pc_d    = redirect_pc;
            // Everything still live becomes stale; accumulate onto any drain in progress.
            discard_d     = discard_d + outstanding_d;
            outstanding_d = '0;
        end else if (accept) begin
            fetch_pc_d = pc_next(fetch_pc_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (buf_push),
        .push_data (rsp_entry),
        .pop       (buf_pop),
        .flush     (redirect),
        .head      (buf_head),
        .count     (buf_count)
    );

    assign buf_empty   = (buf_count == '0);
    assign instr_valid = !buf_empty;
    assign Instruct    = buf_empty ? NOP : buf_head.instr;
    assign instr_pc    = buf_empty ? fetch_pc_q : buf_head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
    import cpu_pkg::*;

    localparam int    DEPTH  = 2;
    localparam word_t RST_PC = 16'h0000;
    localparam word_t NOPW   = 16'hE800;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  halt = 1'b0;
    logic  redirect = 1'b0;
    word_t redirect_pc = '0;
    logic  imem_req;
    word_t imem_addr;
    logic  imem_gnt = 1'b0;
    logic  imem_rvalid = 1'b0;
    word_t imem_rdata = '0;
    word_t Instruct;
    word_t instr_pc;
    logic  instr_valid;

    always #5 clk = ~clk;

    instr_fetch #(
        .RESET_PC (RST_PC),
        .NOP      (NOPW),
        .DEPTH    (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .halt        (halt),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .Instruct    (Instruct),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid)
    );

    // Memory model and scoreboard state
    typedef struct { word_t addr; int epoch; } req_t;
    typedef struct { word_t pc; word_t instr; } exp_t;
    req_t  imemq[$];   // granted, not yet answered
    exp_t  expq[$];    // instructions expected at the DUT output, in order
    int    epoch = 0;
    word_t tb_pc = RST_PC;
    logic  resp_en = 1'b1;
    word_t rv_addr = '0;
    int    rv_epoch = 0;
    int    n_cmp = 0;
    int    n_bad = 0;

    typedef struct {
        bit    rst_before;
        bit    gnt;
        bit    exp_req;
        word_t exp_addr;
        bit    exp_valid;
        word_t exp_pc;
    } vec_t;
    vec_t vecs [13];

    function automatic word_t mem_word(input word_t a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    task automatic chk(input string name, input word_t act, input word_t expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // One clock cycle: inputs already driven; sample and check at negedge,
    // update the model, then advance the memory model after the edge.
    task automatic tick(output logic s_req, output word_t s_addr,
                        output logic s_valid, output word_t s_pc);
        logic  exp_req, acc;
        word_t acc_addr;
        int    acc_epoch;
        req_t  r;
        @(negedge clk);
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = instr_valid;
        s_pc    = instr_pc;
        exp_req = !halt && !redirect &&
                  ((expq.size() + imemq.size() + (imem_rvalid ? 1 : 0)) < DEPTH);
        chk("imem_req", {15'b0, imem_req}, {15'b0, exp_req});
        chk("imem_addr", imem_addr, tb_pc);
        if (!redirect) begin
            chk("instr_valid", {15'b0, instr_valid}, {15'b0, (expq.size() != 0)});
            if (expq.size() != 0) begin
                chk("instr_pc", instr_pc, expq[0].pc);
                chk("Instruct", Instruct, expq[0].instr);
                if (!halt) begin
                    $display("instr pc=%h data=%h", expq[0].pc, expq[0].instr);
                    void'(expq.pop_front());
                end
            end else begin
                chk("nop_instr", Instruct, NOPW);
                chk("nop_pc", instr_pc, tb_pc);
            end
        end
        acc       = exp_req && imem_gnt;
        acc_addr  = tb_pc;
        acc_epoch = epoch;
        if (imem_rvalid && !redirect && (rv_epoch == epoch))
            expq.push_back('{rv_addr, imem_rdata});
        if (redirect) begin
            expq.delete();
            epoch++;
            tb_pc = redirect_pc;
        end else if (acc) begin
            tb_pc = tb_pc + 16'd2;
        end
        @(posedge clk);
        #1;
        if (acc) imemq.push_back('{acc_addr, acc_epoch});
        if (resp_en && (imemq.size() != 0)) begin
            r = imemq.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(r.addr);
            rv_addr     = r.addr;
            rv_epoch    = r.epoch;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 16'h0BAD;
        end
    endtask

    // Asserts reset right now (asynchronously), checks the reset outputs,
    // then releases reset just after a rising edge.
    task automatic do_reset();
        rst = 1'b0;
        halt = 1'b0;
        redirect = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        resp_en = 1'b1;
        imemq.delete();
        expq.delete();
        epoch++;
        tb_pc = RST_PC;
        #1;
        chk("rst_req", {15'b0, imem_req}, 16'h0000);
        chk("rst_instr", Instruct, NOPW);
        chk("rst_valid", {15'b0, instr_valid}, 16'h0000);
        chk("rst_pc", instr_pc, RST_PC);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("rst_hold_pc", instr_pc, RST_PC);
        rst = 1'b1;
        $display("reset released");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic  s_req, s_valid, found;
        word_t s_addr, s_pc;

        // rst_before, gnt, exp_req, exp_addr, exp_valid, exp_pc
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 16'h0002, 1'b0, 16'h0002};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 16'h0004, 1'b1, 16'h0000};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 16'h0004, 1'b1, 16'h0002};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 16'h0006, 1'b0, 16'h0006};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 16'h0008, 1'b1, 16'h0004};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 16'h0002};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 16'h0002, 1'b1, 16'h0000};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 16'h0002};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 16'h0002, 1'b0, 16'h0002};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 16'h0004, 1'b0, 16'h0004};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 16'h0006, 1'b1, 16'h0002};

        #2;
        // Reset release / steady stream, then grant stall
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].rst_before) do_reset();
            imem_gnt = vecs[i].gnt;
            tick(s_req, s_addr, s_valid, s_pc);
            $display("vec %0d: req=%0b addr=%h valid=%0b pc=%h", i, s_req, s_addr, s_valid, s_pc);
            chk("tbl_req", {15'b0, s_req}, {15'b0, vecs[i].exp_req});
            chk("tbl_addr", s_addr, vecs[i].exp_addr);
            chk("tbl_valid", {15'b0, s_valid}, {15'b0, vecs[i].exp_valid});
            chk("tbl_pc", s_pc, vecs[i].exp_pc);
        end

        // Halt with two entries buffered
        do_reset();
        imem_gnt = 1'b1;
        tick(s_req, s_addr, s_valid, s_pc);
        tick(s_req, s_addr, s_valid, s_pc);
        halt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(s_req, s_addr, s_valid, s_pc);
            chk("halt_pc", s_pc, 16'h0000);
            chk("halt_req", {15'b0, s_req}, 16'h0000);
        end
        halt = 1'b0;
        tick(s_req, s_addr, s_valid, s_pc);
        chk("unhalt_pc0", s_pc, 16'h0000);
        tick(s_req, s_addr, s_valid, s_pc);
        chk("unhalt_pc1", s_pc, 16'h0002);
        chk("unhalt_valid1", {15'b0, s_valid}, 16'h0001);

        // Redirect with two requests outstanding
        do_reset();
        resp_en = 1'b0;
        imem_gnt = 1'b1;
        tick(s_req, s_addr, s_valid, s_pc);
        tick(s_req, s_addr, s_valid, s_pc);
        redirect = 1'b1;
        redirect_pc = 16'h0100;
        resp_en = 1'b1;
        tick(s_req, s_addr, s_valid, s_pc);
        chk("redir_req", {15'b0, s_req}, 16'h0000);
        redirect = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick(s_req, s_addr, s_valid, s_pc);
            if (s_valid) begin
                found = 1'b1;
                chk("redir_first_pc", s_pc, 16'h0100);
            end
        end
        if (!found) timeout("redir_first_pc");

        // Redirect and halt in the same cycle, with grant high
        do_reset();
        resp_en = 1'b0;
        imem_gnt = 1'b1;
        tick(s_req, s_addr, s_valid, s_pc);
        redirect = 1'b1;
        halt = 1'b1;
        redirect_pc = 16'h0200;
        resp_en = 1'b1;
        tick(s_req, s_addr, s_valid, s_pc);
        chk("redir_halt_req", {15'b0, s_req}, 16'h0000);
        redirect = 1'b0;
        halt = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick(s_req, s_addr, s_valid, s_pc);
            if (s_valid) begin
                found = 1'b1;
                chk("redir_halt_pc", s_pc, 16'h0200);
            end
        end
        if (!found) timeout("redir_halt_pc");

        // PC wrap at FFFE
        redirect = 1'b1;
        redirect_pc = 16'hFFFE;
        tick(s_req, s_addr, s_valid, s_pc);
        redirect = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick(s_req, s_addr, s_valid, s_pc);
            if (s_req && (s_addr == 16'hFFFE)) found = 1'b1;
        end
        if (!found) timeout("wrap_req");
        tick(s_req, s_addr, s_valid, s_pc);
        chk("wrap_addr", s_addr, 16'h0000);
        for (int k = 0; k < 4; k++) tick(s_req, s_addr, s_valid, s_pc);

        // Reset pulsed mid-burst, then restart at RESET_PC
        imem_gnt = 1'b1;
        tick(s_req, s_addr, s_valid, s_pc);
        do_reset();
        imem_gnt = 1'b1;
        tick(s_req, s_addr, s_valid, s_pc);
        chk("restart_req", {15'b0, s_req}, 16'h0001);
        chk("restart_addr", s_addr, RST_PC);
        for (int k = 0; k < 6; k++) tick(s_req, s_addr, s_valid, s_pc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameters (name, default, meaning); each SHALL be honoured as listed:
- RESET_PC, 16'h0000, first fetch address after reset.
- NOP, 16'hE800, bubble instruction driven when no instruction is available.
- DEPTH, 2, instruction buffer entries.

REQ-002 Ports (name, direction, width, meaning); each SHALL be implemented as listed:
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, asynchronous, active-low reset.
- halt, in, 1, pipeline hold from core.
- redirect, in, 1, branch/jump taken; restart fetch.
- redirect_pc, in, 16, new fetch address, valid with redirect.
- imem_req, out, 1, fetch request.
- imem_addr, out, 16, fetch address.
- imem_gnt, in, 1, request accepted this cycle.
- imem_rvalid, in, 1, read data valid.
- imem_rdata, in, 16, instruction word.
- Instruct, out, 16, instruction to Control.
- instr_pc, out, 16, address of Instruct.
- instr_valid, out, 1, Instruct is a real fetched instruction.

Function
REQ-003 A request SHALL be accepted when imem_req && imem_gnt; imem_addr SHALL equal fetch PC and be held stable while imem_req=1 and imem_gnt=0.
REQ-004 On acceptance, fetch PC SHALL advance by 2 (byte address), wrapping 16'hFFFE -> 16'h0000.
REQ-005 Responses SHALL be treated as in-order, at least 1 cycle after grant; each rvalid pairs with the oldest outstanding request.
REQ-006 imem_req SHALL be asserted only when (buffer count + outstanding count) < DEPTH, halt=0, and redirect=0; overflow is impossible by construction.
REQ-007 Live responses SHALL be written to the buffer with their PC, including while halt=1.
REQ-008 When the buffer is non-empty: Instruct/instr_pc SHALL show the head combinationally, instr_valid=1, and the head SHALL pop on each cycle with halt=0.
REQ-009 When the buffer is empty: Instruct=NOP, instr_pc=fetch PC, instr_valid=0.
REQ-010 While halt=1 and redirect=0: outputs, buffer head and fetch PC SHALL be held; no pop, no new request.
REQ-011 Redirect (cycle N) SHALL take priority over halt and:
- flush the buffer;
- load fetch PC with redirect_pc at edge N;
- drive imem_req=0 in cycle N;
- add all outstanding requests, including one granted in cycle N, to a discard counter.
REQ-012 While the discard counter > 0, each rvalid SHALL decrement it and its data SHALL be dropped; the discard counter SHALL count toward the REQ-006 credit.
REQ-013 First request at redirect_pc SHALL appear in cycle N+1 if credit allows; first valid Instruct SHALL appear no earlier than the cycle after its rvalid is written.
REQ-014 A redirect arriving during a flush SHALL accumulate (discard += outstanding live) without loss of count.
REQ-015 Outstanding and discard counters SHALL be wide enough for DEPTH (2 bits at default) and SHALL never underflow.

Reset
REQ-016 rst=0 SHALL asynchronously clear: buffer, outstanding counter, discard counter; fetch PC <= RESET_PC.
REQ-017 During reset: imem_req=0, Instruct=NOP, instr_valid=0, instr_pc=RESET_PC.
REQ-018 Fetching SHALL begin on the first rising edge after rst deasserts; reset mid-operation SHALL abandon all in-flight state (imem is reset by the same rst).

Structure
REQ-019 NOP, RESET_PC and the 16-bit word width SHALL reside in the shared cpu_pkg, also used by Control.
REQ-020 The buffer SHALL be a sub-module fetch_fifo (DEPTH entries of {pc, instr}, push/pop/flush, count out); credit, discard logic and PC SHALL stay in instr_fetch.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset release, gnt=1, rvalid 1 cycle after grant -> addresses 0000,0002,0004…; Instruct valid from cycle 3; NOP before.
- imem_gnt=0 for 3 cycles -> imem_addr held at 0002, imem_req=1 throughout, no PC advance.
- halt=1 with 2 entries buffered -> Instruct/instr_pc frozen, imem_req=0, no entries lost on halt release.
- Redirect to 0x0100 with 2 outstanding -> next 2 rvalids dropped, next valid Instruct has instr_pc=0x0100.
- Redirect and halt same cycle, plus grant that cycle -> redirect wins, granted response discarded.
- PC at 0xFFFE -> next address 0x0000; rst pulsed mid-burst -> NOP, instr_valid=0, restart at RESET_PC.
